mult_div_unit: RTL and testbench

Multiply/divide unit for the Execute stage of the five-stage MIPS pipeline. It runs mult, multu, div and divu over several cycles and owns the HI/LO registers, with a fixed latency per operation class. It reports busy/stall status to the hazard unit and supplies HI/LO to the Execute output mux for mfhi/mflo. Eout is then registered into EXMEM_Eout.

---
 rtl/mult_div_unit_if.sv | 14 +
 rtl/mult_div_unit.sv | 101 ++++++++++
 tb/tb_mult_div_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/status bundle between the Execute stage and the MDU
interface mult_div_unit_if;
    logic        MD_start;
    logic [2:0]  MD_op;
    logic [31:0] MD_A;
    logic [31:0] MD_B;
    logic        MD_busy;
    logic        MD_stall;
    logic [31:0] MD_HI;
    logic [31:0] MD_LO;

    modport master (output MD_start, MD_op, MD_A, MD_B, input MD_busy, MD_stall, MD_HI, MD_LO);
    modport slave  (input MD_start, MD_op, MD_A, MD_B, output MD_busy, MD_stall, MD_HI, MD_LO);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency multiply/divide unit owning the HI/LO registers
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_res_hi;
    logic [31:0]   r_res_lo;
    logic          r_res_upd;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic          r_busy;

    logic          w_is_mul;
    logic          w_is_div;
    logic          w_mul_sgn;
    logic          w_div_sgn;
    logic [63:0]   w_prod;
    logic          w_neg_a;
    logic          w_neg_b;
    logic [31:0]   w_ua;
    logic [31:0]   w_ub;
    logic [31:0]   w_ub_safe;
    logic [31:0]   w_uq;
    logic [31:0]   w_ur;
    logic [31:0]   w_q;
    logic [31:0]   w_r;
    logic          w_div_zero;

    assign w_is_mul  = (md.MD_op == 3'b001) || (md.MD_op == 3'b010);
    assign w_is_div  = (md.MD_op == 3'b011) || (md.MD_op == 3'b100);
    assign w_mul_sgn = (md.MD_op == 3'b001);
    assign w_div_sgn = (md.MD_op == 3'b011);

    // One 64-bit multiplier serves both flavours: signed operands are sign-extended
    assign w_prod = {{32{w_mul_sgn & md.MD_A[31]}}, md.MD_A} * {{32{w_mul_sgn & md.MD_B[31]}}, md.MD_B};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
    assign w_neg_a    = w_div_sgn & md.MD_A[31];
    assign w_neg_b    = w_div_sgn & md.MD_B[31];
    assign w_ua       = w_neg_a ? -md.MD_A : md.MD_A;
    assign w_ub       = w_neg_b ? -md.MD_B : md.MD_B;
    assign w_div_zero = (md.MD_B == 32'd0);
    assign w_ub_safe  = w_div_zero ? 32'd1 : w_ub;
    assign w_uq       = w_ua / w_ub_safe;
    assign w_ur       = w_ua % w_ub_safe;
    assign w_q        = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
    assign w_r        = w_neg_a ? -w_ur : w_ur;

    assign md.MD_busy  = r_busy;
    assign md.MD_stall = r_busy | (md.MD_start & (w_is_mul | w_is_div));
    assign md.MD_HI    = r_hi;
    assign md.MD_LO    = r_lo;

    // Control FSM: latch result at issue, count down the fixed latency, commit HI/LO at the end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_res_hi  <= '0;
            r_res_lo  <= '0;
            r_res_upd <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
        end else if (r_state == IDLE) begin
            if (md.MD_start && (w_is_mul || w_is_div)) begin
                r_res_hi  <= w_is_mul ? w_prod[63:32] : w_r;
                r_res_lo  <= w_is_mul ? w_prod[31:0] : w_q;
                r_res_upd <= !(w_is_div && w_div_zero);
                r_cnt     <= w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                r_state   <= RUN;
                r_busy    <= 1'b1;
            end else if (md.MD_start && md.MD_op == 3'b101) begin
                r_hi <= md.MD_A;
            end else if (md.MD_start && md.MD_op == 3'b110) begin
                r_lo <= md.MD_A;
            end
        end else if (r_cnt == CW'(1)) begin
            if (r_res_upd) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
            r_cnt   <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit_if bus();

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic written with 64-bit integer operators
    function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output bit upd);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa  = $signed(a);
        sb  = $signed(b);
        hi  = '0;
        lo  = '0;
        upd = 1'b1;
        if (op == 3'b001) begin
            p  = 64'(sa * sb);
            hi = p[63:32];
            lo = p[31:0];
        end else if (op == 3'b010) begin
            p  = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            upd = 1'b0;
        end else if (op == 3'b011) begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inj);
        logic [31:0] eh;
        logic [31:0] el;
        bit upd;
        int n;
        n = (op <= 3'b010) ? MC : DC;
        ref_md(op, a, b, eh, el, upd);
        bus.MD_start = 1'b1;
        bus.MD_op    = op;
        bus.MD_A     = a;
        bus.MD_B     = b;
        #1;
        tests++;
        if (bus.MD_stall !== 1'b1 || bus.MD_busy !== 1'b0) begin
            fails++;
            $display("FAIL issue_stall op=%0d got stall=%b busy=%b exp stall=1 busy=0", op, bus.MD_stall, bus.MD_busy);
        end
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) bus.MD_start = 1'b0;
            if (inj && i == 3) begin
                bus.MD_start = 1'b1;
                bus.MD_op    = 3'b001;
                bus.MD_A     = $urandom;
                bus.MD_B     = $urandom;
            end
            if (inj && i == 4) bus.MD_start = 1'b0;
            #1;
            tests++;
            if (bus.MD_busy !== 1'b1 || bus.MD_stall !== 1'b1 || bus.MD_HI !== m_hi || bus.MD_LO !== m_lo) begin
                fails++;
                $display("FAIL busy_cycle op=%0d c%0d got busy=%b stall=%b hi=%h lo=%h exp busy=1 stall=1 hi=%h lo=%h",
                         op, i, bus.MD_busy, bus.MD_stall, bus.MD_HI, bus.MD_LO, m_hi, m_lo);
            end
        end
        @(posedge clk);
        #1;
        if (upd) begin
            m_hi = eh;
            m_lo = el;
        end
        tests++;
        if (bus.MD_busy !== 1'b0 || bus.MD_stall !== 1'b0 || bus.MD_HI !== m_hi || bus.MD_LO !== m_lo) begin
            fails++;
            $display("FAIL result op=%0d a=%h b=%h got busy=%b stall=%b hi=%h lo=%h exp busy=0 stall=0 hi=%h lo=%h",
                     op, a, b, bus.MD_busy, bus.MD_stall, bus.MD_HI, bus.MD_LO, m_hi, m_lo);
        end
    endtask

    task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
        bus.MD_start = 1'b1;
        bus.MD_op    = op;
        bus.MD_A     = a;
        bus.MD_B     = $urandom;
        #1;
        tests++;
        if (bus.MD_stall !== 1'b0 || bus.MD_busy !== 1'b0) begin
            fails++;
            $display("FAIL mt_stall op=%0d got stall=%b busy=%b exp 0 0", op, bus.MD_stall, bus.MD_busy);
        end
        @(posedge clk);
        #1;
        bus.MD_start = 1'b0;
        if (op == 3'b101) m_hi = a;
        if (op == 3'b110) m_lo = a;
        #1;
        tests++;
        if (bus.MD_HI !== m_hi || bus.MD_LO !== m_lo || bus.MD_busy !== 1'b0) begin
            fails++;
            $display("FAIL mt_write op=%0d got hi=%h lo=%h busy=%b exp hi=%h lo=%h busy=0",
                     op, bus.MD_HI, bus.MD_LO, bus.MD_busy, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.MD_start = 1'b1;
        bus.MD_op    = 3'b001;
        bus.MD_A     = 32'd3;
        bus.MD_B     = 32'd4;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.MD_busy !== 1'b0 || bus.MD_HI !== 32'd0 || bus.MD_LO !== 32'd0 || bus.MD_stall !== 1'b1) begin
            fails++;
            $display("FAIL reset_state got busy=%b hi=%h lo=%h stall=%b exp 0 0 0 1", bus.MD_busy, bus.MD_HI, bus.MD_LO, bus.MD_stall);
        end
        bus.MD_op = 3'b101;
        #1;
        tests++;
        if (bus.MD_stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_stall_mthi got %b exp 0", bus.MD_stall);
        end
        bus.MD_start = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult();
        run_md(3'b001, 32'hFFFFFFFD, 32'd5, 1'b0);
        tests++;
        if (bus.MD_HI !== 32'hFFFFFFFF || bus.MD_LO !== 32'hFFFFFFF1) begin
            fails++;
            $display("FAIL mult_const got hi=%h lo=%h exp FFFFFFFF FFFFFFF1", bus.MD_HI, bus.MD_LO);
        end
    endtask

    task automatic test_multu_div();
        run_md(3'b010, 32'hFFFFFFFF, 32'd2, 1'b0);
        tests++;
        if (bus.MD_HI !== 32'h00000001 || bus.MD_LO !== 32'hFFFFFFFE) begin
            fails++;
            $display("FAIL multu_const got hi=%h lo=%h exp 00000001 FFFFFFFE", bus.MD_HI, bus.MD_LO);
        end
        run_md(3'b011, 32'hFFFFFFF9, 32'd2, 1'b0);
        tests++;
        if (bus.MD_HI !== 32'hFFFFFFFF || bus.MD_LO !== 32'hFFFFFFFD) begin
            fails++;
            $display("FAIL div_const got hi=%h lo=%h exp FFFFFFFF FFFFFFFD", bus.MD_HI, bus.MD_LO);
        end
    endtask

    task automatic test_mthi_mtlo();
        do_mt(3'b101, 32'h12345678);
        do_mt(3'b110, 32'h9ABCDEF0);
        do_mt(3'b111, 32'hDEADBEEF);
        do_mt(3'b000, 32'hCAFEF00D);
    endtask

    task automatic test_div_edges();
        do_mt(3'b101, 32'hAAAA0000);
        do_mt(3'b110, 32'h0000BBBB);
        run_md(3'b100, 32'd7, 32'd0, 1'b0);
        tests++;
        if (bus.MD_HI !== 32'hAAAA0000 || bus.MD_LO !== 32'h0000BBBB) begin
            fails++;
            $display("FAIL divu_zero got hi=%h lo=%h exp AAAA0000 0000BBBB", bus.MD_HI, bus.MD_LO);
        end
        run_md(3'b011, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        tests++;
        if (bus.MD_HI !== 32'd0 || bus.MD_LO !== 32'h80000000) begin
            fails++;
            $display("FAIL div_overflow got hi=%h lo=%h exp 00000000 80000000", bus.MD_HI, bus.MD_LO);
        end
    endtask

    task automatic test_ignore_in_run();
        run_md(3'b011, 32'd1000, 32'd7, 1'b1);
        run_md(3'b100, $urandom, 32'd13, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_md(3'b001, $urandom, $urandom, 1'b0);
        run_md(3'b100, $urandom, $urandom_range(1, 1000), 1'b0);
        run_md(3'b010, $urandom, $urandom, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int k = 0; k < 30; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if (op >= 3'b001 && op <= 3'b100) run_md(op, a, b, 1'b0);
            else do_mt(op, a);
        end
    endtask

    task automatic test_reset_mid_run();
        bus.MD_start = 1'b1;
        bus.MD_op    = 3'b011;
        bus.MD_A     = 32'd100;
        bus.MD_B     = 32'd3;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            bus.MD_start = 1'b0;
            #1;
            tests++;
            if (bus.MD_busy !== 1'b1) begin
                fails++;
                $display("FAIL rst_pre_busy c%0d got %b exp 1", i, bus.MD_busy);
            end
        end
        #1;
        reset = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        tests++;
        if (bus.MD_busy !== 1'b0 || bus.MD_HI !== 32'd0 || bus.MD_LO !== 32'd0) begin
            fails++;
            $display("FAIL rst_async got busy=%b hi=%h lo=%h exp 0 0 0", bus.MD_busy, bus.MD_HI, bus.MD_LO);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < DC + 2; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (bus.MD_busy !== 1'b0 || bus.MD_HI !== 32'd0 || bus.MD_LO !== 32'd0) begin
                fails++;
                $display("FAIL rst_no_late_write c%0d got busy=%b hi=%h lo=%h exp 0 0 0", i, bus.MD_busy, bus.MD_HI, bus.MD_LO);
            end
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        m_hi         = '0;
        m_lo         = '0;
        bus.MD_start = 1'b0;
        bus.MD_op    = 3'b000;
        bus.MD_A     = '0;
        bus.MD_B     = '0;
        test_reset();
        test_mult();
        test_multu_div();
        test_mthi_mtlo();
        test_div_edges();
        test_ignore_in_run();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
